// File: rtl/cordic_sweep_gen.sv
// Sweep command generator feeding the combinational CORDIC rotator: holds a fixed
// vector and steps the rotation angle once per accepted valid/ready handshake.
module cordic_sweep_gen #(
  parameter int unsigned VW = 11,
  parameter int unsigned AW = 9,
  parameter int unsigned CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic signed [VW-1:0] vx_init,
  input  logic signed [VW-1:0] vy_init,
  input  logic        [AW-1:0] z_start,
  input  logic        [AW-1:0] z_step,
  input  logic        [CW-1:0] count,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic signed [VW-1:0] Vx,
  output logic signed [VW-1:0] Vy,
  output logic        [AW-1:0] Z0,
  output logic        [CW-1:0] idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e        state;
  logic [AW-1:0] step;
  logic [CW-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      out_valid <= 1'b0;
      Vx        <= '0;
      Vy        <= '0;
      Z0        <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            Vx        <= vx_init;
            Vy        <= vy_init;
            Z0        <= z_start;
            step      <= z_step;
            remaining <= count;
            idx       <= '0;
            if (count != '0) begin
              state     <= StRun;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              // Empty sweep still completes normally and reports done.
              state <= StFin;
              done  <= 1'b1;
            end
          end
        end
        StRun: begin
          // Abort wins over a coincident handshake; that command counts as unconsumed.
          if (abort) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            if (remaining == CW'(1)) begin
              state     <= StFin;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              Z0        <= Z0 + step;
              idx       <= idx + CW'(1);
              remaining <= remaining - CW'(1);
            end
          end
        end
        StFin: begin
          state     <= StIdle;
          done      <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sweep_gen.sv
// Directed bench for cordic_sweep_gen: inputs change and outputs are sampled 1 ns
// after each rising edge, with expected values worked out by hand.
module tb_cordic_sweep_gen;

  localparam int unsigned VW = 11;
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 8;

  logic                 clk = 1'b0;
  logic                 rst, start, abort, out_ready;
  logic signed [VW-1:0] vx_init, vy_init;
  logic        [AW-1:0] z_start, z_step;
  logic        [CW-1:0] count;
  logic                 out_valid, busy, done;
  logic signed [VW-1:0] Vx, Vy;
  logic        [AW-1:0] Z0;
  logic        [CW-1:0] idx;

  int passed = 0;
  int total  = 0;

  cordic_sweep_gen #(.VW(VW), .AW(AW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .vx_init   (vx_init),
    .vy_init   (vy_init),
    .z_start   (z_start),
    .z_step    (z_step),
    .count     (count),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .Vx        (Vx),
    .Vy        (Vy),
    .Z0        (Z0),
    .idx       (idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    int exp_z;
    int exp_i;
    int z_list[3];
    bit ready_pat[7];

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    vx_init = '0; vy_init = '0; z_start = '0; z_step = '0; count = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_z0", 32'(Z0), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_vx", 32'(Vx), 0);

    // Basic sweep: 8 commands, one per cycle.
    vx_init = 11'sd256; vy_init = 11'sd0; z_start = 9'd0; z_step = 9'd64; count = 8'd8;
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("basic_valid", 32'(out_valid), 1);
      chk("basic_busy", 32'(busy), 1);
      chk("basic_z0", 32'(Z0), 32'(i * 64));
      chk("basic_idx", 32'(idx), 32'(i));
      chk("basic_vx", 32'(Vx), 256);
      chk("basic_vy", 32'(Vy), 0);
      chk("basic_done_low", 32'(done), 0);
      tick();
    end
    chk("basic_done", 32'(done), 1);
    chk("basic_busy_end", 32'(busy), 0);
    chk("basic_valid_end", 32'(out_valid), 0);
    tick();
    chk("basic_done_pulse", 32'(done), 0);

    // Wrap-around, started back-to-back on the first IDLE cycle after done.
    vx_init = -11'sd5; vy_init = -11'sd100; z_start = 9'd500; z_step = 9'd20; count = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    z_list = '{500, 8, 28};
    for (int i = 0; i < 3; i++) begin
      chk("wrap_valid", 32'(out_valid), 1);
      chk("wrap_z0", 32'(Z0), 32'(z_list[i]));
      chk("wrap_idx", 32'(idx), 32'(i));
      tick();
    end
    chk("wrap_vx", 32'(Vx), 32'(-5));
    chk("wrap_vy", 32'(Vy), 32'(-100));
    chk("wrap_done", 32'(done), 1);
    tick();

    // Backpressure: ready pattern 1,0,0,1,1,0,1 gives exactly 4 handshakes.
    vx_init = 11'sd1; vy_init = 11'sd2; z_start = 9'd10; z_step = 9'd100; count = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_z = 10;
    exp_i = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = ready_pat[i];
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_z0", 32'(Z0), 32'(exp_z));
      chk("bp_idx", 32'(idx), 32'(exp_i));
      chk("bp_done_low", 32'(done), 0);
      tick();
      if (ready_pat[i]) begin
        exp_z = (exp_z + 100) % 512;
        exp_i++;
      end
    end
    chk("bp_done", 32'(done), 1);
    chk("bp_valid_end", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();

    // count=0: done on the cycle after start, out_valid never rises.
    z_start = 9'd77; count = 8'd0; start = 1'b1;
    tick();
    chk("zero_valid", 32'(out_valid), 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_z0", 32'(Z0), 77);
    // Start held into FIN must be ignored even with a nonzero count.
    count = 8'd5;
    tick();
    start = 1'b0;
    chk("fin_start_valid", 32'(out_valid), 0);
    chk("fin_start_done", 32'(done), 0);
    tick();
    chk("fin_start_idle", 32'(out_valid), 0);

    // Abort together with ready after 2 handshakes.
    z_start = 9'd0; z_step = 9'd1; count = 8'd6; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("abort_pre_z0", 32'(Z0), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_z0", 32'(Z0), 2);
    chk("abort_idx", 32'(idx), 2);
    tick();
    chk("abort_done_after", 32'(done), 0);
    chk("abort_idle_valid", 32'(out_valid), 0);

    // Start during RUN is ignored; then reset mid-sweep after 4 handshakes.
    z_start = 9'd100; z_step = 9'd3; count = 8'd10; out_ready = 1'b0; start = 1'b1;
    tick();
    z_start = 9'd7; count = 8'd2;
    tick();
    start = 1'b0;
    chk("ign_start_z0", 32'(Z0), 100);
    chk("ign_start_idx", 32'(idx), 0);
    chk("ign_start_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("pre_rst_z0", 32'(Z0), 112);
    chk("pre_rst_idx", 32'(idx), 4);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_idx", 32'(idx), 0);
    chk("mid_rst_z0", 32'(Z0), 0);
    chk("mid_rst_done", 32'(done), 0);
    tick();
    chk("mid_rst_done2", 32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
